// File: rtl/pim_tile_scheduler.sv
// rtl/pim_tile_scheduler.sv - splits one square matmul into tile jobs and dispatches them to PIM units
// One job in flight per unit; done pulses once every unit has finished its last job.
module pim_tile_scheduler #(
  parameter int NUM_UNITS   = 4,
  parameter int MATRIX_SIZE = 4,
  parameter int CAP         = 2,
  parameter int LEN         = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN-1:0]       base_a,
  input  logic [LEN-1:0]       base_b,
  input  logic [LEN-1:0]       base_c,
  output logic [NUM_UNITS-1:0] job_valid,
  input  logic [NUM_UNITS-1:0] job_ready,
  output logic [LEN-1:0]       job_a_addr,
  output logic [LEN-1:0]       job_b_addr,
  output logic [LEN-1:0]       job_c_addr,
  output logic                 job_acc,
  output logic                 job_last,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int T      = MATRIX_SIZE / CAP;
  localparam int TILES  = T * T;
  localparam int GROUPS = (TILES + NUM_UNITS - 1) / NUM_UNITS;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int KW     = (T > 1) ? $clog2(T) : 1;
  localparam int SW     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int ROW    = CAP * MATRIX_SIZE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [GW-1:0]        r_grp;
  logic [KW-1:0]        r_k;
  logic [SW-1:0]        r_slot;
  logic [NUM_UNITS-1:0] r_busy;
  logic [LEN-1:0]       r_base_a;
  logic [LEN-1:0]       r_base_b;
  logic [LEN-1:0]       r_base_c;
  logic                 r_done;
  logic                 r_err;

  logic [31:0]          w_tile;
  logic [31:0]          w_tr;
  logic [31:0]          w_tc;
  logic [LEN-1:0]       w_a;
  logic [LEN-1:0]       w_b;
  logic [LEN-1:0]       w_c;
  logic                 w_issue;
  logic                 w_accept;
  logic                 w_slot_last;
  logic                 w_k_last;
  logic                 w_grp_last;
  logic                 w_final;
  logic                 w_hs;
  logic                 w_err_evt;
  logic [NUM_UNITS-1:0] w_sel;
  logic [NUM_UNITS-1:0] w_fire;

  assign w_tile = 32'(r_grp) * NUM_UNITS + 32'(r_slot);
  assign w_tr   = w_tile / T;
  assign w_tc   = w_tile % T;
  assign w_a    = LEN'(32'(r_base_a) + w_tr * ROW + 32'(r_k) * CAP);
  assign w_b    = LEN'(32'(r_base_b) + 32'(r_k) * ROW + w_tc * CAP);
  assign w_c    = LEN'(32'(r_base_c) + w_tr * ROW + w_tc * CAP);

  // Slots whose tile index runs past TILES only occur at the tail of a group,
  // so treating the last populated slot as the wrap point skips them in 0 cycles.
  assign w_slot_last = (r_slot == SW'(NUM_UNITS - 1)) || (w_tile + 1 >= TILES);
  assign w_k_last    = (r_k == KW'(T - 1));
  assign w_grp_last  = (r_grp == GW'(GROUPS - 1));
  assign w_final     = w_slot_last & w_k_last & w_grp_last;

  assign w_issue  = (r_state == S_ISSUE);
  assign w_accept = (r_state == S_IDLE) & start;
  assign w_sel    = NUM_UNITS'(1) << r_slot;

  assign job_valid  = (w_issue && !r_busy[r_slot]) ? w_sel : '0;
  assign job_a_addr = w_issue ? w_a : '0;
  assign job_b_addr = w_issue ? w_b : '0;
  assign job_c_addr = w_issue ? w_c : '0;
  assign job_acc    = w_issue & (r_k != '0);
  assign job_last   = w_issue & w_k_last;

  assign w_fire    = job_valid & job_ready;
  assign w_hs      = |w_fire;
  assign w_err_evt = |(unit_done & ~r_busy) | |(job_ready & ~job_valid);

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grp    <= '0;
      r_k      <= '0;
      r_slot   <= '0;
      r_busy   <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_busy & ~unit_done) | w_fire;
      r_err  <= (w_accept ? 1'b0 : r_err) | w_err_evt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base_a <= base_a;
            r_base_b <= base_b;
            r_base_c <= base_c;
            r_grp    <= '0;
            r_k      <= '0;
            r_slot   <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_hs) begin
            if (w_final) begin
              r_state <= S_DRAIN;
            end else if (!w_slot_last) begin
              r_slot <= r_slot + 1'b1;
            end else begin
              r_slot <= '0;
              if (!w_k_last) begin
                r_k <= r_k + 1'b1;
              end else begin
                r_k   <= '0;
                r_grp <= r_grp + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_busy == '0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_tile_scheduler.sv
// tb/tb_pim_tile_scheduler.sv - scoreboard bench for pim_tile_scheduler
// Unit model returns unit_done 3 cycles after each accepted job.
module tb_pim_tile_scheduler;

  localparam int NU     = 4;
  localparam int MS     = 4;
  localparam int CAP    = 2;
  localparam int T      = MS / CAP;
  localparam int TILES  = T * T;
  localparam int GROUPS = (TILES + NU - 1) / NU;

  typedef struct {
    int         u;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] c;
    logic       acc;
    logic       last;
  } job_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    base_a = '0;
  logic [9:0]    base_b = '0;
  logic [9:0]    base_c = '0;
  logic [NU-1:0] job_valid;
  logic [NU-1:0] job_ready = '0;
  logic [9:0]    job_a_addr;
  logic [9:0]    job_b_addr;
  logic [9:0]    job_c_addr;
  logic          job_acc;
  logic          job_last;
  logic [NU-1:0] unit_done = '0;
  logic          busy;
  logic          done;
  logic          err;

  int   checks = 0;
  int   failures = 0;
  int   cnt[NU];
  job_t exp_q[$];

  pim_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a_addr(job_a_addr), .job_b_addr(job_b_addr), .job_c_addr(job_c_addr),
    .job_acc(job_acc), .job_last(job_last), .unit_done(unit_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick_units();
    unit_done = '0;
    for (int u = 0; u < NU; u++) begin
      if (cnt[u] > 0) begin
        cnt[u]--;
        if (cnt[u] == 0) unit_done[u] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_units();
      job_ready = '0;
    end
  endtask

  task automatic push_run(input int ba, input int bb, input int bc);
    job_t e;
    for (int g = 0; g < GROUPS; g++)
      for (int k = 0; k < T; k++)
        for (int s = 0; s < NU; s++) begin
          int tile, tr, tc;
          tile = g * NU + s;
          if (tile < TILES) begin
            tr     = tile / T;
            tc     = tile % T;
            e.u    = s;
            e.a    = 10'((ba + tr * CAP * MS + k * CAP) % 1024);
            e.b    = 10'((bb + k * CAP * MS + tc * CAP) % 1024);
            e.c    = 10'((bc + tr * CAP * MS + tc * CAP) % 1024);
            e.acc  = (k != 0);
            e.last = (k == T - 1);
            exp_q.push_back(e);
          end
        end
  endtask

  task automatic do_start(input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc);
    @(negedge clk);
    tick_units();
    job_ready = '0;
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    @(negedge clk);
    tick_units();
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL start_clears_err got=%0b exp=0", err); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%0b exp=1", busy); end
    checks++;
    if (job_valid !== 4'b0001) begin failures++; $display("FAIL first_valid got=%b exp=0001", job_valid); end
  endtask

  task automatic run_engine(input int stall_unit, input int restart_at, input int reset_at,
                            output int hs, output int dones);
    int            post, stall_left, stall_cycles, u;
    bit            seen, finished, stall_started, restarted;
    logic [NU-1:0] rdy, fire, prev_valid;
    logic [31:0]   prev_pay;
    job_t          e;
    hs = 0; dones = 0; post = 0; stall_left = 0; stall_cycles = 0;
    seen = 0; finished = 0; stall_started = 0; restarted = 0;
    prev_valid = '0; prev_pay = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      tick_units();
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        seen = 1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%0b exp=0", busy); end
      end
      if (seen) begin
        post++;
        if (post > 3) begin finished = 1; break; end
      end
      if (reset_at >= 0 && hs == reset_at) begin
        rst_n = 1'b0;
        job_ready = '0;
        #1;
        checks++;
        if ({job_valid, busy, done, err} !== 7'b0) begin
          failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {job_valid, busy, done, err});
        end
        checks++;
        if ({job_a_addr, job_b_addr, job_c_addr, job_acc, job_last} !== 32'b0) begin
          failures++; $display("FAIL reset_payload got=%h exp=0", {job_a_addr, job_b_addr, job_c_addr, job_acc, job_last});
        end
        return;
      end
      rdy = '1;
      if (stall_unit >= 0) begin
        if (!stall_started && job_valid[stall_unit]) begin stall_started = 1; stall_left = 10; end
        if (stall_left > 0) begin
          rdy[stall_unit] = 1'b0;
          stall_left--;
          if (job_valid[stall_unit]) stall_cycles++;
        end
      end
      job_ready = rdy;
      fire = job_valid & job_ready;
      if (prev_valid != '0) begin
        checks++;
        if ({job_valid, job_a_addr, job_b_addr, job_c_addr, job_acc, job_last} !== {prev_valid, prev_pay}) begin
          failures++; $display("FAIL hold_stable got=%h exp=%h",
            {job_valid, job_a_addr, job_b_addr, job_c_addr, job_acc, job_last}, {prev_valid, prev_pay});
        end
      end
      prev_valid = (fire == '0) ? job_valid : '0;
      prev_pay   = {job_a_addr, job_b_addr, job_c_addr, job_acc, job_last};
      if (fire != '0) begin
        checks++;
        if (!$onehot(fire)) begin failures++; $display("FAIL onehot got=%b exp=one_bit", fire); end
        u = 0;
        for (int i = 0; i < NU; i++) if (fire[i]) u = i;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL extra_job got=%0d exp=none", hs);
        end else begin
          e = exp_q.pop_front();
          if (u != e.u) begin failures++; $display("FAIL job_unit got=%0d exp=%0d", u, e.u); end
          checks++;
          if (job_a_addr !== e.a) begin failures++; $display("FAIL job_a got=%0d exp=%0d", job_a_addr, e.a); end
          checks++;
          if (job_b_addr !== e.b) begin failures++; $display("FAIL job_b got=%0d exp=%0d", job_b_addr, e.b); end
          checks++;
          if (job_c_addr !== e.c) begin failures++; $display("FAIL job_c got=%0d exp=%0d", job_c_addr, e.c); end
          checks++;
          if ({job_acc, job_last} !== {e.acc, e.last}) begin
            failures++; $display("FAIL job_flags got=%b exp=%b", {job_acc, job_last}, {e.acc, e.last});
          end
        end
        cnt[u] = 3;
        hs++;
      end
      if (restart_at >= 0 && hs == restart_at && !restarted) begin
        restarted = 1;
        start = 1'b1;
        base_a = 10'd100; base_b = 10'd200; base_c = 10'd300;
      end
    end
    checks++;
    if (!finished) begin failures++; $display("FAIL run_timeout got=%0d exp=done", hs); end
    if (stall_unit >= 0) begin
      checks++;
      if (stall_cycles != 10) begin failures++; $display("FAIL stall_cycles got=%0d exp=10", stall_cycles); end
    end
    job_ready = '0;
  endtask

  task automatic check_run(input string name, input int hs, input int dones);
    checks++;
    if (hs != 8) begin failures++; $display("FAIL %s_handshakes got=%0d exp=8", name, hs); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", name, dones); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL %s_missing_jobs got=%0d exp=0", name, exp_q.size()); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({job_valid, busy, done, err} !== 7'b0) begin
      failures++; $display("FAIL por_ctrl got=%b exp=0000000", {job_valid, busy, done, err});
    end
    checks++;
    if ({job_a_addr, job_b_addr, job_c_addr, job_acc, job_last} !== 32'b0) begin
      failures++; $display("FAIL por_payload got=%h exp=0", {job_a_addr, job_b_addr, job_c_addr, job_acc, job_last});
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checks++;
    if ({job_valid, busy} !== 5'b0) begin failures++; $display("FAIL idle_after_reset got=%b exp=00000", {job_valid, busy}); end
  endtask

  task automatic test_basic();
    int hs, dn;
    push_run(0, 16, 32);
    do_start(10'd0, 10'd16, 10'd32);
    run_engine(-1, -1, -1, hs, dn);
    check_run("basic", hs, dn);
    idle(5);
  endtask

  task automatic test_stall();
    int hs, dn;
    push_run(0, 16, 32);
    do_start(10'd0, 10'd16, 10'd32);
    run_engine(2, -1, -1, hs, dn);
    check_run("stall", hs, dn);
    idle(5);
  endtask

  task automatic test_spurious_done();
    int hs, dn;
    @(negedge clk);
    job_ready = '0;
    unit_done = 4'b0010;
    @(negedge clk);
    unit_done = '0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL spurious_done_err got=%0b exp=1", err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL spurious_done_busy got=%0b exp=0", busy); end
    push_run(0, 16, 32);
    do_start(10'd0, 10'd16, 10'd32);
    run_engine(-1, -1, -1, hs, dn);
    check_run("after_err", hs, dn);
    idle(5);
  endtask

  task automatic test_restart_ignored();
    int hs, dn;
    push_run(0, 16, 32);
    do_start(10'd0, 10'd16, 10'd32);
    run_engine(-1, 2, -1, hs, dn);
    check_run("restart", hs, dn);
    idle(5);
  endtask

  task automatic test_wrap();
    int hs, dn;
    push_run(0, 16, 1020);
    do_start(10'd0, 10'd16, 10'd1020);
    run_engine(-1, -1, -1, hs, dn);
    check_run("wrap", hs, dn);
    idle(5);
  endtask

  task automatic test_mid_reset();
    int hs, dn;
    push_run(0, 16, 32);
    do_start(10'd0, 10'd16, 10'd32);
    run_engine(-1, -1, 5, hs, dn);
    checks++;
    if (hs != 5) begin failures++; $display("FAIL jobs_before_reset got=%0d exp=5", hs); end
    @(negedge clk);
    tick_units();
    rst_n = 1'b1;
    idle(6);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL late_done_err got=%0b exp=1", err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
    exp_q.delete();
    push_run(0, 16, 32);
    do_start(10'd0, 10'd16, 10'd32);
    run_engine(-1, -1, -1, hs, dn);
    check_run("replay", hs, dn);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) cnt[u] = 0;
    test_reset();
    test_basic();
    test_stall();
    test_spurious_done();
    test_restart_ignored();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
